// File: rtl/cache_load_l1_data_if.sv
// cache_load_l1_data_if: core request/response and L1 data array signals grouped for the load unit
interface cache_load_l1_data_if #(
  parameter int offset_size = 2,
  parameter int word_size   = 2,
  parameter int block_size  = 128
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [2:0]             load_instruction_i;
  logic [word_size-1:0]   word_i;
  logic [offset_size-1:0] offset_i;
  logic                   rd_en_o;
  logic [block_size-1:0]  data_L1_i;
  logic                   resp_valid_o;
  logic                   resp_ready_i;
  logic [63:0]            data_core_o;
  logic                   err_o;
  modport master (
    output req_valid_i, load_instruction_i, word_i, offset_i, data_L1_i, resp_ready_i,
    input  req_ready_o, rd_en_o, resp_valid_o, data_core_o, err_o
  );
  modport slave (
    input  req_valid_i, load_instruction_i, word_i, offset_i, data_L1_i, resp_ready_i,
    output req_ready_o, rd_en_o, resp_valid_o, data_core_o, err_o
  );
endinterface

// File: rtl/cache_load_l1_data.sv
// cache_load_l1_data: L1 data load unit that reads a block, extracts and extends the addressed datum
module cache_load_l1_data #(
  parameter int offset_size = 2,
  parameter int word_size   = 2,
  parameter int block_size  = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cache_load_l1_data_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t                 r_state, w_next;
  logic [2:0]             r_funct;
  logic [word_size-1:0]   r_word;
  logic [offset_size-1:0] r_offset;
  logic [63:0]            r_data;
  logic                   r_err;
  logic                   w_accept, w_legal, w_sgn;
  logic [2:0]             w_f;
  logic [63:0]            w_sb, w_sw, w_sd, w_ext;
  assign w_f = bus.load_instruction_i;
  assign w_legal = w_f == 3'b111       ? 1'b0 :
                   w_f[1:0] == 2'd0    ? 1'b1 :
                   w_f[1:0] == 2'd1    ? bus.offset_i != {offset_size{1'b1}} :
                   w_f[1:0] == 2'd2    ? bus.offset_i == '0 :
                                         bus.offset_i == '0 && !bus.word_i[0];
  // Shift the block so the addressed byte, word or doubleword lands at bit 0
  assign w_sb  = 64'(bus.data_L1_i >> {r_word, r_offset, 3'b000});
  assign w_sw  = 64'(bus.data_L1_i >> {r_word, 5'b00000});
  assign w_sd  = 64'(bus.data_L1_i >> {r_word[word_size-1:1], 6'b000000});
  assign w_sgn = !r_funct[2];
  assign w_ext = r_funct[1:0] == 2'd0 ? {{56{w_sgn & w_sb[7]}},  w_sb[7:0]}  :
                 r_funct[1:0] == 2'd1 ? {{48{w_sgn & w_sb[15]}}, w_sb[15:0]} :
                 r_funct[1:0] == 2'd2 ? {{32{w_sgn & w_sw[31]}}, w_sw[31:0]} :
                                        w_sd;
  assign bus.data_core_o = r_data;
  assign bus.err_o       = r_err;
  // Handshake outputs and next state; illegal requests skip the array read and go straight to RESP
  always_comb begin
    w_next           = r_state;
    w_accept         = 1'b0;
    bus.req_ready_o  = 1'b0;
    bus.rd_en_o      = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.req_ready_o  = rst_ni && r_state == IDLE;
    w_accept         = rst_ni && r_state == IDLE && bus.req_valid_i;
    bus.rd_en_o      = w_accept && w_legal;
    bus.resp_valid_o = r_state == RESP;
    w_next = r_state == IDLE ? (w_accept ? (w_legal ? READ : RESP) : IDLE) :
             r_state == READ ? RESP :
             (bus.resp_ready_i ? IDLE : RESP);
  end
  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end
  // Request latch and response register; READ captures the array data returned after rd_en_o
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_funct  <= '0;
      r_word   <= '0;
      r_offset <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct  <= bus.load_instruction_i;
        r_word   <= bus.word_i;
        r_offset <= bus.offset_i;
      end
      if (w_accept && !w_legal) begin
        r_data <= '0;
        r_err  <= 1'b1;
      end
      if (r_state == READ) begin
        r_data <= w_ext;
        r_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cache_load_l1_data.sv
// tb_cache_load_l1_data: directed checks of extraction, extension, legality, latency, backpressure and reset
module tb_cache_load_l1_data;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [127:0] blk1, blk2;
  cache_load_l1_data_if #(.offset_size(2), .word_size(2), .block_size(128)) bus ();
  cache_load_l1_data #(.offset_size(2), .word_size(2), .block_size(128)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic ld(input string tag, input logic [2:0] f, input logic [1:0] w, input logic [1:0] o,
                    input logic [63:0] exp, input logic bad);
    bus.req_valid_i = 1'b1;
    bus.load_instruction_i = f;
    bus.word_i = w;
    bus.offset_i = o;
    #1;
    chk({tag, " rd_en"}, 64'(bus.rd_en_o), 64'(!bad));
    chk({tag, " req_ready"}, 64'(bus.req_ready_o), 64'd1);
    tick();
    bus.req_valid_i = 1'b0;
    if (!bad) begin
      chk({tag, " rvalid_read"}, 64'(bus.resp_valid_o), 64'd0);
      chk({tag, " rd_en_read"}, 64'(bus.rd_en_o), 64'd0);
      tick();
    end
    chk({tag, " rvalid"}, 64'(bus.resp_valid_o), 64'd1);
    chk({tag, " data"}, bus.data_core_o, exp);
    chk({tag, " err"}, 64'(bus.err_o), 64'(bad));
    bus.resp_ready_i = 1'b1;
    tick();
    bus.resp_ready_i = 1'b0;
    chk({tag, " rvalid_done"}, 64'(bus.resp_valid_o), 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) blk1[8*i +: 8] = 8'(i);
    blk1[8*11 +: 8] = 8'h80;
    blk1[8*5 +: 8]  = 8'h34;
    blk1[8*6 +: 8]  = 8'h92;
    blk2 = 128'h8877665544332211_0123456789ABCDEF;
    rst_ni = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.load_instruction_i = 3'b000;
    bus.word_i = 2'd0;
    bus.offset_i = 2'd0;
    bus.resp_ready_i = 1'b0;
    bus.data_L1_i = blk1;
    tick();
    tick();
    chk("rst req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst rd_en", 64'(bus.rd_en_o), 64'd0);
    chk("rst rvalid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst data", bus.data_core_o, 64'd0);
    chk("rst err", 64'(bus.err_o), 64'd0);
    bus.req_valid_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    chk("idle req_ready", 64'(bus.req_ready_o), 64'd1);
    ld("LB b11",  3'b000, 2'd2, 2'd3, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    ld("LBU b11", 3'b100, 2'd2, 2'd3, 64'h0000_0000_0000_0080, 1'b0);
    ld("LH b5",   3'b001, 2'd1, 2'd1, 64'hFFFF_FFFF_FFFF_9234, 1'b0);
    ld("LHU b5",  3'b101, 2'd1, 2'd1, 64'h0000_0000_0000_9234, 1'b0);
    ld("LH o3",   3'b001, 2'd1, 2'd3, 64'd0, 1'b1);
    ld("F111",    3'b111, 2'd0, 2'd0, 64'd0, 1'b1);
    bus.data_L1_i = blk2;
    ld("LD w2",   3'b011, 2'd2, 2'd0, 64'h8877665544332211, 1'b0);
    ld("LD w0",   3'b011, 2'd0, 2'd0, 64'h0123456789ABCDEF, 1'b0);
    ld("LW w3",   3'b010, 2'd3, 2'd0, 64'hFFFF_FFFF_8877_6655, 1'b0);
    ld("LWU w1",  3'b110, 2'd1, 2'd0, 64'h0000_0000_0123_4567, 1'b0);
    ld("LH b14",  3'b001, 2'd3, 2'd2, 64'hFFFF_FFFF_FFFF_8877, 1'b0);
    ld("LHU b14", 3'b101, 2'd3, 2'd2, 64'h0000_0000_0000_8877, 1'b0);
    ld("LW o1",   3'b010, 2'd0, 2'd1, 64'd0, 1'b1);
    ld("LD w1",   3'b011, 2'd1, 2'd0, 64'd0, 1'b1);
    ld("LB b0",   3'b000, 2'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0);
    bus.resp_ready_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.load_instruction_i = 3'b100;
    bus.word_i = 2'd3;
    bus.offset_i = 2'd3;
    tick();
    bus.req_valid_i = 1'b0;
    chk("early_ready rvalid_read", 64'(bus.resp_valid_o), 64'd0);
    tick();
    chk("early_ready rvalid", 64'(bus.resp_valid_o), 64'd1);
    chk("early_ready data", bus.data_core_o, 64'h0000_0000_0000_0088);
    tick();
    bus.resp_ready_i = 1'b0;
    chk("early_ready done", 64'(bus.resp_valid_o), 64'd0);
    bus.req_valid_i = 1'b1;
    bus.load_instruction_i = 3'b010;
    bus.word_i = 2'd0;
    bus.offset_i = 2'd0;
    tick();
    bus.load_instruction_i = 3'b111;
    bus.word_i = 2'd1;
    bus.offset_i = 2'd1;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("bp rvalid", 64'(bus.resp_valid_o), 64'd1);
      chk("bp data", bus.data_core_o, 64'hFFFF_FFFF_89AB_CDEF);
      chk("bp err", 64'(bus.err_o), 64'd0);
      chk("bp req_ready", 64'(bus.req_ready_o), 64'd0);
      chk("bp rd_en", 64'(bus.rd_en_o), 64'd0);
      tick();
    end
    bus.req_valid_i = 1'b0;
    bus.resp_ready_i = 1'b1;
    tick();
    bus.resp_ready_i = 1'b0;
    chk("bp done rvalid", 64'(bus.resp_valid_o), 64'd0);
    chk("bp done req_ready", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.load_instruction_i = 3'b011;
    bus.word_i = 2'd2;
    bus.offset_i = 2'd0;
    tick();
    rst_ni = 1'b0;
    #1;
    chk("rst_read req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_read rd_en", 64'(bus.rd_en_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    bus.req_valid_i = 1'b0;
    chk("rst_read data", bus.data_core_o, 64'd0);
    chk("rst_read err", 64'(bus.err_o), 64'd0);
    for (int c = 0; c < 4; c++) begin
      chk("rst_read rvalid", 64'(bus.resp_valid_o), 64'd0);
      tick();
    end
    ld("LD after rst", 3'b011, 2'd2, 2'd0, 64'h8877665544332211, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_load_l1_data.md
CACHE_LOAD_L1_DATA -- requirements
Module: cache_load_l1_data

Interface
REQ-001 Parameters SHALL be: offset_size, default 2, byte-offset-within-word width; word_size, default 2, word-within-block width; block_size, default 128, L1 data block width in bits.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset; synchronous, active-low.
REQ-004 req_valid_i  input  1  core load request valid.
REQ-005 req_ready_o  output  1  block can accept a request.
REQ-006 load_instruction_i  input  3  RISC-V load funct3: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
REQ-007 word_i  input  word_size  word index within block.
REQ-008 offset_i  input  offset_size  byte offset within word.
REQ-009 rd_en_o  output  1  read strobe to L1 data array.
REQ-010 data_L1_i  input  block_size  L1 data array read data, valid the cycle after rd_en_o.
REQ-011 resp_valid_o  output  1  load response valid.
REQ-012 resp_ready_i  input  1  core accepts response.
REQ-013 data_core_o  output  64  extended load result.
REQ-014 err_o  output  1  misaligned or illegal request; qualified by resp_valid_o.

Function
REQ-015 Block byte b SHALL occupy data_L1_i[8b+7:8b]; the addressed byte index SHALL be {word_i, offset_i} (0..15); bytes 0-7 form the low doubleword and bytes 8-15 the high doubleword.
REQ-016 States SHALL be IDLE, READ and RESP.
REQ-017 req_ready_o SHALL be 1 only in IDLE with rst_ni high; a request is accepted on any edge where req_valid_i and req_ready_o are both 1.
REQ-018 On accept, the block SHALL latch load_instruction_i, word_i and offset_i.
REQ-019 Legality: LB/LBU are always legal; LH/LHU require offset_i != 3; LW/LWU require offset_i == 0; LD requires offset_i == 0 and word_i[0] == 0; funct3 111 is illegal.
REQ-020 rd_en_o SHALL be combinational, equal to accept AND legal; it SHALL be 0 in every other cycle.
REQ-021 A legal accept SHALL move IDLE->READ. In READ, the block SHALL capture data_L1_i, register the extracted and extended result in data_core_o, set err_o=0, and move to RESP.
REQ-022 An illegal accept SHALL move IDLE->RESP directly, with data_core_o=0 and err_o=1; no array read SHALL occur.
REQ-023 Extraction SHALL work as follows: LB/LBU use byte idx; LH/LHU use bytes idx..idx+1, with the higher byte as MSB (little-endian); LW/LWU use word word_i, i.e. bits [32w+31:32w]; LD uses doubleword word_i[1], i.e. bits [64d+63:64d].
REQ-024 LB/LH/LW SHALL sign-extend to 64 bits; LBU/LHU/LWU SHALL zero-extend; LD SHALL pass through unchanged.
REQ-025 In RESP, resp_valid_o SHALL be 1 and data_core_o and err_o SHALL be held stable; when resp_ready_i is 1, the block SHALL move to IDLE.
REQ-026 Latency SHALL be as follows: for a legal request accepted at edge N, resp_valid_o rises after edge N+1; for an illegal request, after edge N. Minimum legal throughput is one load per 3 cycles.
REQ-027 Requests presented while not in IDLE SHALL be ignored (not accepted), with no side effects.
REQ-028 resp_ready_i asserted outside RESP SHALL have no effect.

Reset
REQ-029 When rst_ni is low at an edge: state SHALL become IDLE; resp_valid_o=0; err_o=0; data_core_o=0; latched request fields cleared to 0.
REQ-030 While rst_ni is low, req_ready_o and rd_en_o SHALL be 0.
REQ-031 Reset in READ or RESP SHALL abandon the request; no response SHALL be produced after reset release.

Verification
REQ-032 LB, word_i=2, offset_i=3, block byte 11=0x80 -> rd_en_o=1 in accept cycle; resp_valid_o two cycles later; data_core_o=0xFFFF_FFFF_FFFF_FF80, err_o=0.
REQ-033 Same request as LBU -> data_core_o=0x0000_0000_0000_0080.
REQ-034 LH, word_i=1, offset_i=1, byte5=0x34, byte6=0x92 -> data_core_o=0xFFFF_FFFF_FFFF_9234. Same request as LHU -> 0x0000_0000_0000_9234.
REQ-035 LH, offset_i=3, or funct3=111 -> rd_en_o stays 0; resp_valid_o one cycle after accept; err_o=1; data_core_o=0.
REQ-036 LD, word_i=2, block=0x8877665544332211_0123456789ABCDEF (high:low doubleword) -> data_core_o=0x8877665544332211. LW, word_i=3 on the same block -> 0xFFFF_FFFF_8877_6655.
REQ-037 Backpressure and reset: hold resp_ready_i=0 for 3 cycles in RESP while driving req_valid_i=1 -> output stable, req_ready_o=0, no accept. Assert rst_ni=0 during READ -> resp_valid_o never asserts for that request.
